// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the pipelined MIPS-style core.
//
// Computes the ALU result for the instruction held in the ID/EX slot and
// registers it, together with the memory/write-back controls, into the
// EX/MEM outputs. Single-cycle operations complete in one clock; MUL runs a
// 32-iteration shift-add sequence and stalls upstream while it does so.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   validI, flushI          slot holds a real instruction / squash it
//   regDstI .. regWriteI    decoded single-bit controls
//   aluOpI                  ALU operation code
//   instruccionSiguienteI   PC+4 of the instruction (branch base)
//   readData1I/readData2I   register operands A and rt value
//   signExtendI             sign-extended immediate
//   jumpDirI                jump target, passed through
//   rtI, rdI                destination register candidates
//   stallO                  upstream must hold its inputs while high
//   validO .. zeroO         registered EX/MEM controls and zero flag
//   aluResultO, writeDataO, branchTargetO, jumpDirO, writeRegO
//                           registered EX/MEM data
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         validI,
    input  logic         flushI,
    input  logic         regDstI,
    input  logic         jumpI,
    input  logic         branchI,
    input  logic         memReadI,
    input  logic         memToRegI,
    input  logic         memWriteI,
    input  logic         aluSrcI,
    input  logic         regWriteI,
    input  logic [3:0]   aluOpI,
    input  logic [W-1:0] instruccionSiguienteI,
    input  logic [W-1:0] readData1I,
    input  logic [W-1:0] readData2I,
    input  logic [W-1:0] signExtendI,
    input  logic [W-1:0] jumpDirI,
    input  logic [4:0]   rtI,
    input  logic [4:0]   rdI,
    output logic         stallO,
    output logic         validO,
    output logic         memReadO,
    output logic         memWriteO,
    output logic         memToRegO,
    output logic         regWriteO,
    output logic         jumpO,
    output logic         pcSrcO,
    output logic         zeroO,
    output logic [W-1:0] aluResultO,
    output logic [W-1:0] writeDataO,
    output logic [W-1:0] branchTargetO,
    output logic [W-1:0] jumpDirO,
    output logic [4:0]   writeRegO
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam int               CNT_W     = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

    // Single-cycle ALU. MUL is not handled here; it goes through the FSM.
    function automatic logic [W-1:0] aluCompute(input logic [3:0]   op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return (sa < sb) ? W'(1) : '0;
            OP_NOR:  return ~(a | b);
            default: return '0;
        endcase
    endfunction

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     mulA;
    logic [W-1:0]     mulB;
    logic [W-1:0]     acc;

    // Copies of the MUL instruction's side-band fields; upstream has already
    // moved on once stallO rises, so the ports cannot be used at completion.
    logic             mulMemRead;
    logic             mulMemWrite;
    logic             mulMemToReg;
    logic             mulRegWrite;
    logic             mulJump;
    logic             mulBranch;
    logic [4:0]       mulWriteReg;
    logic [W-1:0]     mulWriteData;
    logic [W-1:0]     mulBranchTarget;
    logic [W-1:0]     mulJumpDir;

    logic [W-1:0]     opB;
    logic             accept;
    logic             isMul;
    logic [W-1:0]     aluNow;
    logic [W-1:0]     targetNow;
    logic [4:0]       writeRegNow;
    logic [W-1:0]     partial;
    logic [W-1:0]     accNext;

    assign opB         = aluSrcI ? signExtendI : readData2I;
    assign accept      = validI && !flushI;
    assign isMul       = (aluOpI == OP_MUL);
    assign aluNow      = aluCompute(aluOpI, readData1I, opB);
    assign targetNow   = instruccionSiguienteI + (signExtendI << 2);
    assign writeRegNow = regDstI ? rdI : rtI;

    // One shift-add step: bit cnt of the multiplier selects A shifted by cnt.
    assign partial = mulB[cnt] ? (mulA << cnt) : '0;
    assign accNext = acc + partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            mulA            <= '0;
            mulB            <= '0;
            mulMemRead      <= 1'b0;
            mulMemWrite     <= 1'b0;
            mulMemToReg     <= 1'b0;
            mulRegWrite     <= 1'b0;
            mulJump         <= 1'b0;
            mulBranch       <= 1'b0;
            mulWriteReg     <= '0;
            mulWriteData    <= '0;
            mulBranchTarget <= '0;
            mulJumpDir      <= '0;
            stallO          <= 1'b0;
            validO          <= 1'b0;
            memReadO        <= 1'b0;
            memWriteO       <= 1'b0;
            memToRegO       <= 1'b0;
            regWriteO       <= 1'b0;
            jumpO           <= 1'b0;
            pcSrcO          <= 1'b0;
            zeroO           <= 1'b0;
            aluResultO      <= '0;
            writeDataO      <= '0;
            branchTargetO   <= '0;
            jumpDirO        <= '0;
            writeRegO       <= '0;
        end else begin
            // Bubble by default: side-effecting controls drop, data holds.
            validO    <= 1'b0;
            memReadO  <= 1'b0;
            memWriteO <= 1'b0;
            regWriteO <= 1'b0;
            jumpO     <= 1'b0;
            pcSrcO    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !isMul) begin
                        validO        <= 1'b1;
                        memReadO      <= memReadI;
                        memWriteO     <= memWriteI;
                        memToRegO     <= memToRegI;
                        regWriteO     <= regWriteI;
                        jumpO         <= jumpI;
                        pcSrcO        <= branchI && (aluNow == '0);
                        zeroO         <= (aluNow == '0);
                        aluResultO    <= aluNow;
                        writeDataO    <= readData2I;
                        branchTargetO <= targetNow;
                        jumpDirO      <= jumpDirI;
                        writeRegO     <= writeRegNow;
                    end else if (accept) begin
                        mulA            <= readData1I;
                        mulB            <= opB;
                        acc             <= '0;
                        cnt             <= '0;
                        mulMemRead      <= memReadI;
                        mulMemWrite     <= memWriteI;
                        mulMemToReg     <= memToRegI;
                        mulRegWrite     <= regWriteI;
                        mulJump         <= jumpI;
                        mulBranch       <= branchI;
                        mulWriteReg     <= writeRegNow;
                        mulWriteData    <= readData2I;
                        mulBranchTarget <= targetNow;
                        mulJumpDir      <= jumpDirI;
                        stallO          <= 1'b1;
                        state           <= MUL;
                    end
                end
                MUL: begin
                    if (flushI) begin
                        stallO <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == LAST_ITER) begin
                        // Final iteration folds straight into the output.
                        validO        <= 1'b1;
                        memReadO      <= mulMemRead;
                        memWriteO     <= mulMemWrite;
                        memToRegO     <= mulMemToReg;
                        regWriteO     <= mulRegWrite;
                        jumpO         <= mulJump;
                        pcSrcO        <= mulBranch && (accNext == '0);
                        zeroO         <= (accNext == '0);
                        aluResultO    <= accNext;
                        writeDataO    <= mulWriteData;
                        branchTargetO <= mulBranchTarget;
                        jumpDirO      <= mulJumpDir;
                        writeRegO     <= mulWriteReg;
                        stallO        <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        acc <= accNext;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    stallO <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        validI, flushI, regDstI, jumpI, branchI, memReadI, memToRegI;
    logic        memWriteI, aluSrcI, regWriteI;
    logic [3:0]  aluOpI;
    logic [31:0] instruccionSiguienteI, readData1I, readData2I, signExtendI, jumpDirI;
    logic [4:0]  rtI, rdI;
    logic        stallO, validO, memReadO, memWriteO, memToRegO, regWriteO;
    logic        jumpO, pcSrcO, zeroO;
    logic [31:0] aluResultO, writeDataO, branchTargetO, jumpDirO;
    logic [4:0]  writeRegO;

    int tests = 0;
    int fails = 0;

    ex_stage #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .validI(validI), .flushI(flushI),
        .regDstI(regDstI), .jumpI(jumpI), .branchI(branchI),
        .memReadI(memReadI), .memToRegI(memToRegI), .memWriteI(memWriteI),
        .aluSrcI(aluSrcI), .regWriteI(regWriteI), .aluOpI(aluOpI),
        .instruccionSiguienteI(instruccionSiguienteI), .readData1I(readData1I),
        .readData2I(readData2I), .signExtendI(signExtendI), .jumpDirI(jumpDirI),
        .rtI(rtI), .rdI(rdI), .stallO(stallO), .validO(validO),
        .memReadO(memReadO), .memWriteO(memWriteO), .memToRegO(memToRegO),
        .regWriteO(regWriteO), .jumpO(jumpO), .pcSrcO(pcSrcO), .zeroO(zeroO),
        .aluResultO(aluResultO), .writeDataO(writeDataO),
        .branchTargetO(branchTargetO), .jumpDirO(jumpDirO), .writeRegO(writeRegO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic anyOutput();
        return |{stallO, validO, memReadO, memWriteO, memToRegO, regWriteO, jumpO,
                 pcSrcO, zeroO, aluResultO, writeDataO, branchTargetO, jumpDirO, writeRegO};
    endfunction

    // Reference ALU straight from the operation table.
    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            4'b1000: r = a * b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          mBusy;
    int          mRem;
    logic [31:0] pRes, pWriteData, pTarget, pJumpDir;
    logic [4:0]  pWriteReg;
    logic        pMemRead, pMemWrite, pMemToReg, pRegWrite, pJump, pBranch;
    logic        eValid, eStall, eMemRead, eMemWrite, eMemToReg, eRegWrite, eJump, ePcSrc, eZero;
    logic [31:0] eRes, eWriteData, eTarget, eJumpDir;
    logic [4:0]  eWriteReg;

    initial begin
        logic [31:0] b;
        bit emit;
        mBusy = 0;
        mRem  = 0;
        eStall = 0;
        forever begin
            @(posedge clk);
            emit = 0;
            eValid = 0; eMemRead = 0; eMemWrite = 0; eRegWrite = 0; eJump = 0; ePcSrc = 0;
            if (!rst_n) begin
                mBusy = 0;
                eStall = 0;
            end else if (!mBusy) begin
                if (validI && !flushI) begin
                    b = aluSrcI ? signExtendI : readData2I;
                    pRes       = refAlu(aluOpI, readData1I, b);
                    pMemRead   = memReadI;  pMemWrite = memWriteI; pMemToReg = memToRegI;
                    pRegWrite  = regWriteI; pJump     = jumpI;     pBranch   = branchI;
                    pWriteReg  = regDstI ? rdI : rtI;
                    pWriteData = readData2I;
                    pTarget    = instruccionSiguienteI + signExtendI * 32'd4;
                    pJumpDir   = jumpDirI;
                    if (aluOpI == 4'b1000) begin
                        mBusy  = 1;
                        mRem   = 32;
                        eStall = 1;
                    end else begin
                        emit = 1;
                    end
                end
            end else begin
                if (flushI) begin
                    mBusy  = 0;
                    eStall = 0;
                end else begin
                    mRem--;
                    if (mRem == 0) begin
                        mBusy  = 0;
                        eStall = 0;
                        emit   = 1;
                    end
                end
            end
            if (emit) begin
                eValid = 1; eMemRead = pMemRead; eMemWrite = pMemWrite; eMemToReg = pMemToReg;
                eRegWrite = pRegWrite; eJump = pJump; eZero = (pRes == 0);
                ePcSrc = pBranch && eZero;
                eRes = pRes; eWriteData = pWriteData; eTarget = pTarget;
                eJumpDir = pJumpDir; eWriteReg = pWriteReg;
            end
            #1;
            check("ctrl{valid,stall,mr,mw,rw,j,pcs}",
                  64'({validO, stallO, memReadO, memWriteO, regWriteO, jumpO, pcSrcO}),
                  64'({eValid, eStall, eMemRead, eMemWrite, eRegWrite, eJump, ePcSrc}));
            if (eValid) begin
                check("aluResult", 64'(aluResultO), 64'(eRes));
                check("writeReg", 64'(writeRegO), 64'(eWriteReg));
                check("writeData", 64'(writeDataO), 64'(eWriteData));
                check("branchTarget", 64'(branchTargetO), 64'(eTarget));
                check("jumpDir", 64'(jumpDirO), 64'(eJumpDir));
                check("zero_memToReg", 64'({zeroO, memToRegO}), 64'({eZero, eMemToReg}));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clearInputs();
        validI = 0; flushI = 0; regDstI = 0; jumpI = 0; branchI = 0; memReadI = 0;
        memToRegI = 0; memWriteI = 0; aluSrcI = 0; regWriteI = 0; aluOpI = 4'b0010;
        instruccionSiguienteI = 0; readData1I = 0; readData2I = 0; signExtendI = 0;
        jumpDirI = 0; rtI = 0; rdI = 0;
    endtask

    task automatic setInstr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b2,
                            input logic [31:0] sext, input logic aSrc, input logic rDst,
                            input logic [4:0] rt, input logic [4:0] rd, input logic br,
                            input logic [31:0] npc);
        validI = 1; flushI = 0; aluOpI = op; readData1I = a; readData2I = b2;
        signExtendI = sext; aluSrcI = aSrc; regDstI = rDst; rtI = rt; rdI = rd;
        branchI = br; instruccionSiguienteI = npc; regWriteI = 1; memReadI = 0;
        memWriteI = 0; memToRegI = 0; jumpI = 0; jumpDirI = 32'h0040_0000;
    endtask

    function automatic logic [31:0] randOperand();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom();
    endfunction

    initial begin
        logic [3:0] ops [8];
        int stallCnt;
        int validEdge;
        bit sawValid;
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b0011; ops[7] = 4'b1111;

        clearInputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs_zero", 64'(anyOutput()), 64'd0);
        @(negedge clk) rst_n = 1;

        // ADD 5+7, rd selected
        @(negedge clk) setInstr(4'b0010, 32'd5, 32'd7, 32'd0, 0, 1, 5'd9, 5'd3, 0, 32'd0);
        @(posedge clk); #1;
        check("add_result", 64'(aluResultO), 64'd12);
        check("add_writeReg", 64'(writeRegO), 64'd3);
        check("add_zero_valid", 64'({zeroO, validO}), 64'b01);
        validI = 0;

        // SUB equal operands with branch -> taken
        @(negedge clk) setInstr(4'b0110, 32'd9, 32'd9, 32'd4, 0, 0, 5'd1, 5'd2, 1, 32'h100);
        @(posedge clk); #1;
        check("sub_result", 64'(aluResultO), 64'd0);
        check("sub_zero_pcSrc", 64'({zeroO, pcSrcO}), 64'b11);
        check("sub_branchTarget", 64'(branchTargetO), 64'h110);
        validI = 0;

        // SLT signed -1 < 1, then wrapping ADD
        @(negedge clk) setInstr(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 5'd4, 5'd5, 0, 32'd0);
        @(posedge clk); #1;
        check("slt_signed", 64'(aluResultO), 64'd1);
        @(negedge clk) setInstr(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 5'd4, 5'd5, 0, 32'd0);
        @(posedge clk); #1;
        check("add_wrap", 64'({aluResultO, 31'd0, zeroO}), 64'd1);
        validI = 0;

        // MUL latency and product
        @(negedge clk) setInstr(4'b1000, 32'h10001, 32'h10001, 32'd0, 0, 1, 5'd0, 5'd7, 0, 32'd0);
        stallCnt = 0; validEdge = 0;
        for (int c = 1; c <= 40 && validEdge == 0; c++) begin
            @(posedge clk); #1;
            validI = 0;
            if (stallO) stallCnt++;
            if (validO) validEdge = c;
        end
        check("mul_stall_cycles", 64'(stallCnt), 64'd32);
        check("mul_valid_edge", 64'(validEdge), 64'd33);
        check("mul_product", 64'(aluResultO), 64'h0002_0001);

        // flush at MUL cycle 10
        @(negedge clk) setInstr(4'b1000, 32'd3, 32'd5, 32'd0, 0, 1, 5'd0, 5'd8, 0, 32'd0);
        @(posedge clk); #1 validI = 0;
        repeat (9) @(posedge clk);
        #1 flushI = 1;
        @(posedge clk); #1;
        check("flush_stall_valid_rw", 64'({stallO, validO, regWriteO}), 64'd0);
        flushI = 0;
        sawValid = 0;
        repeat (34) begin
            @(posedge clk); #1;
            if (validO) sawValid = 1;
        end
        check("flush_no_late_result", 64'(sawValid), 64'd0);

        // reset at MUL cycle 5
        @(negedge clk) setInstr(4'b1000, 32'd11, 32'd13, 32'd0, 0, 1, 5'd0, 5'd9, 0, 32'd0);
        @(posedge clk); #1 validI = 0;
        repeat (4) @(posedge clk);
        #3 rst_n = 0;
        #1 check("reset_mid_mul_immediate", 64'(anyOutput()), 64'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(negedge clk) setInstr(4'b0010, 32'd2, 32'd3, 32'd0, 0, 0, 5'd6, 5'd0, 0, 32'd0);
        @(posedge clk); #1;
        check("post_reset_add", 64'({validO, aluResultO}), {31'd0, 1'b1, 32'd5});
        validI = 0;

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            validI    = ($urandom_range(0, 9) != 0);
            flushI    = ($urandom_range(0, 99) == 0);
            aluOpI    = ($urandom_range(0, 19) == 0) ? 4'b1000 : ops[$urandom_range(0, 7)];
            readData1I = randOperand();
            readData2I = ($urandom_range(0, 4) == 0) ? readData1I : randOperand();
            signExtendI = randOperand();
            instruccionSiguienteI = $urandom();
            jumpDirI  = $urandom();
            aluSrcI   = 1'($urandom_range(0, 1));
            regDstI   = 1'($urandom_range(0, 1));
            jumpI     = 1'($urandom_range(0, 1));
            branchI   = 1'($urandom_range(0, 1));
            memReadI  = 1'($urandom_range(0, 1));
            memWriteI = 1'($urandom_range(0, 1));
            memToRegI = 1'($urandom_range(0, 1));
            regWriteI = 1'($urandom_range(0, 1));
            rtI       = 5'($urandom_range(0, 31));
            rdI       = 5'($urandom_range(0, 31));
        end
        @(negedge clk) clearInputs();
        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter W, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port validI, input, 1, upstream ID/EX slot holds a real instruction.
REQ-005 SHALL have port flushI, input, 1, squash the current instruction.
REQ-006 SHALL have ports regDstI, jumpI, branchI, memReadI, memToRegI, memWriteI, aluSrcI, regWriteI, input, 1 each, decoded controls.
REQ-007 SHALL have port aluOpI, input, 4, ALU operation.
REQ-008 SHALL have ports instruccionSiguienteI, readData1I, readData2I, signExtendI, jumpDirI, input, 32 each.
REQ-009 SHALL have ports rtI, rdI, input, 5 each, destination candidates.
REQ-010 SHALL have port stallO, output, 1, registered; upstream holds all inputs while high.
REQ-011 SHALL have ports validO, memReadO, memWriteO, memToRegO, regWriteO, jumpO, pcSrcO, zeroO, output, 1 each, registered EX/MEM controls.
REQ-012 SHALL have ports aluResultO, writeDataO, branchTargetO, jumpDirO, output, 32 each, registered.
REQ-013 SHALL have port writeRegO, output, 5, registered destination register.

Function
REQ-014 Operand B SHALL be signExtendI if aluSrcI=1, else readData2I; operand A SHALL be readData1I.
REQ-015 aluOpI encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 1000 MUL (low 32 bits, unsigned); other codes SHALL yield 0.
REQ-016 ADD/SUB/MUL SHALL wrap mod 2^32; no overflow flag or trap.
REQ-017 State machine SHALL have states IDLE and MUL.
REQ-018 In IDLE with validI=1, flushI=0, non-MUL op: next edge registers result, validO=1, latency 1 cycle.
REQ-019 In IDLE with validI=1, flushI=0, op MUL: next edge latches A, B and all controls, clears accumulator, sets counter 0, stallO=1, validO=0, enters MUL.
REQ-020 In MUL, one shift-add iteration per cycle; after 32 iterations (counter 31) the edge registers product, validO=1, stallO=0, returns to IDLE; total latency 33 cycles.
REQ-021 In MUL, input port values SHALL be ignored (latched copies used).
REQ-022 writeRegO SHALL be rdI if regDstI=1, else rtI; writeDataO SHALL be readData2I.
REQ-023 branchTargetO SHALL be instruccionSiguienteI + (signExtendI << 2), mod 2^32; jumpDirO passes jumpDirI.
REQ-024 zeroO SHALL be 1 iff registered result equals 0; pcSrcO SHALL be branch & zero & validO.
REQ-025 Bubble (validI=0 or flushI=1 in IDLE): next edge validO, memReadO, memWriteO, regWriteO, jumpO, pcSrcO SHALL be 0; data outputs don't-care.
REQ-026 flushI=1 in MUL SHALL abort: next edge IDLE, stallO=0, bubble outputs per REQ-025.
REQ-027 Outputs SHALL hold their previous values during MUL except validO=0 and bubble controls 0 (at most one valid result per instruction).

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, counter 0, accumulator 0, every output 0, regardless of clk.
REQ-029 Reset asserted mid-MUL SHALL discard the operation; first edge after release behaves as IDLE.

Verification
REQ-030 ADD: A=5, B=7, aluSrc=0, regDst=1, rd=3 -> next cycle aluResultO=12, writeRegO=3, zeroO=0, validO=1.
REQ-031 SUB branch: A=B=9, op 0110, branchI=1, instruccionSiguienteI=0x100, signExtendI=4 -> aluResultO=0, zeroO=1, pcSrcO=1, branchTargetO=0x110.
REQ-032 SLT signed: A=0xFFFFFFFF, B=1 -> aluResultO=1; ADD 0xFFFFFFFF+1 -> 0, zeroO=1.
REQ-033 MUL: A=0x10001, B=0x10001 -> stallO high 32 cycles, validO=1 on cycle 33 with aluResultO=0x00020001.
REQ-034 flushI at MUL cycle 10 -> next edge stallO=0, validO=0, regWriteO=0; rst_n low at MUL cycle 5 -> all outputs 0 immediately.
